// File: rtl/dcp_pkg.sv
// dcp_pkg: shared constants, type codes and state encoding for the debug-unit command processors
package dcp_pkg;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic TX_CHAR = 1'b0;
  localparam logic TX_HEX  = 1'b1;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_CNT, HDR_D, HDR_DASH, PR_ADDR, PR_COLON,
    RD, WAIT_RD, PR_SP, PR_DATA, PR_CR, PR_LF, DONE
  } state_e;
endpackage

// File: rtl/dcp_req_hs.sv
// dcp_req_hs: request/acknowledge holder; payload is latched at request start and held until ack
module dcp_req_hs #(
  parameter int W = 33,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         start,
  input  logic         ack,
  input  logic [W-1:0] pay_in,
  output logic         req,
  output logic [W-1:0] pay,
  output logic         fire
);
  logic req_q, req_d;
  logic [W-1:0] pay_q, pay_d;
  assign req  = req_q;
  assign pay  = pay_q;
  assign fire = req_q && ack;
  always_comb begin
    req_d = !clr && !fire && (start || req_q);
    pay_d = (!clr && start && !req_q) ? pay_in : pay_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      req_q <= 1'b0;
      pay_q <= RST_VAL;
    end else begin
      req_q <= req_d;
      pay_q <= pay_d;
    end
endmodule

// File: rtl/dcp_dump.sv
// dcp_dump: memory-dump command processor printing a header and formatted lines of memory words
module dcp_dump
  import dcp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int MAX_LINES = 16,
  parameter int RD_LAT = 1,
  parameter logic [7:0] CMD_CODE = CMD_DUMP
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        sel_mode,
  output logic              req_rx,
  output logic              type_rx,
  input  logic              ack_rx,
  input  logic              flag_rx,
  input  logic [31:0]       din_rx,
  output logic              req_tx,
  output logic              type_tx,
  output logic [31:0]       dout_tx,
  input  logic              ack_tx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              finish,
  output logic [3:0]        cs
);
  localparam int WCW = $clog2(WORDS_PER_LINE + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, last_addr_q, last_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [15:0] lines_q, lines_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic mem_rd_q, mem_rd_d, finish_q, finish_d;
  logic en, abort, rx_fire, tx_fire, rx_start, tx_start;
  logic [7:0] ch;
  logic [32:0] tx_pay;
  assign en       = sel_mode == CMD_CODE;
  assign abort    = state_q != IDLE && !en;
  assign rx_start = state_q inside {GET_ADDR, GET_CNT} && !req_rx;
  assign tx_start = state_q inside {HDR_D, HDR_DASH, PR_ADDR, PR_COLON, PR_SP, PR_DATA, PR_CR, PR_LF} && !req_tx;
  assign ch = state_q == HDR_D ? CH_D : state_q == HDR_DASH ? CH_DASH : state_q == PR_COLON ? CH_COLON :
              state_q == PR_SP ? CH_SP : state_q == PR_CR ? CH_CR : CH_LF;
  assign tx_pay = state_q == PR_ADDR ? {TX_HEX, 32'(cur_addr_q)} :
                  state_q == PR_DATA ? {TX_HEX, 32'(word_q)} : {TX_CHAR, 24'd0, ch};
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign finish   = finish_q;
  assign cs       = state_q;
  dcp_req_hs #(.W(1), .RST_VAL(1'b1)) u_rx (
    .clk(clk), .rstn(rstn), .clr(abort), .start(rx_start), .ack(ack_rx),
    .pay_in(1'b1), .req(req_rx), .pay(type_rx), .fire(rx_fire)
  );
  dcp_req_hs #(.W(33), .RST_VAL(33'd0)) u_tx (
    .clk(clk), .rstn(rstn), .clr(abort), .start(tx_start), .ack(ack_tx),
    .pay_in(tx_pay), .req(req_tx), .pay({type_tx, dout_tx}), .fire(tx_fire)
  );
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    word_d     = word_q;
    lines_d    = lines_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      IDLE:     state_d = en ? GET_ADDR : IDLE;
      GET_ADDR: if (rx_fire) begin
        cur_addr_d = flag_rx ? last_addr_q : din_rx[ADDR_W-1:0];
        state_d    = GET_CNT;
      end
      GET_CNT:  if (rx_fire) begin
        lines_d = (flag_rx || din_rx == '0) ? 16'd1 : (din_rx > 32'(MAX_LINES)) ? 16'(MAX_LINES) : din_rx[15:0];
        state_d = HDR_D;
      end
      HDR_D:    state_d = tx_fire ? HDR_DASH : HDR_D;
      HDR_DASH: state_d = tx_fire ? PR_ADDR : HDR_DASH;
      PR_ADDR:  state_d = tx_fire ? PR_COLON : PR_ADDR;
      PR_COLON: if (tx_fire) begin
        wcnt_d  = '0;
        state_d = RD;
      end
      RD:       state_d = WAIT_RD;
      WAIT_RD:  if (vld_q[RD_LAT-1]) begin
        word_d     = mem_data;
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        state_d    = PR_SP;
      end
      PR_SP:    state_d = tx_fire ? PR_DATA : PR_SP;
      PR_DATA:  if (tx_fire) begin
        wcnt_d  = wcnt_q + WCW'(1);
        state_d = wcnt_q == WCW'(WORDS_PER_LINE - 1) ? PR_CR : RD;
      end
      PR_CR:    state_d = tx_fire ? PR_LF : PR_CR;
      PR_LF:    if (tx_fire) begin
        lines_d = lines_q - 16'd1;
        state_d = lines_q == 16'd1 ? DONE : PR_ADDR;
      end
      default:  state_d = en ? DONE : IDLE;
    endcase
    if (abort) state_d = IDLE;
    // last_addr only moves on a completed line, so an abort leaves it at a line boundary
    last_addr_d = (state_d == PR_CR && state_q != PR_CR) ? cur_addr_q : last_addr_q;
    mem_rd_d    = state_d == RD;
    mem_addr_d  = state_d == RD ? cur_addr_q : mem_addr_q;
    vld_d       = abort ? '0 : RD_LAT'({vld_q, mem_rd_q});
    finish_d    = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      mem_addr_q  <= '0;
      word_q      <= '0;
      lines_q     <= '0;
      wcnt_q      <= '0;
      vld_q       <= '0;
      mem_rd_q    <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      mem_addr_q  <= mem_addr_d;
      word_q      <= word_d;
      lines_q     <= lines_d;
      wcnt_q      <= wcnt_d;
      vld_q       <= vld_d;
      mem_rd_q    <= mem_rd_d;
      finish_q    <= finish_d;
    end
endmodule

// File: tb/tb_dcp_dump.sv
// tb_dcp_dump: table-driven dump commands with a transmit scoreboard, plus abort and reset sequences
module tb_dcp_dump;
  import dcp_pkg::*;
  localparam int RD_LAT = 3, WPL = 8, MAXL = 16;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] sel_mode;
  logic req_rx, type_rx, ack_rx, flag_rx, req_tx, type_tx, ack_tx, mem_rd, finish;
  logic [31:0] din_rx, dout_tx, mem_addr, mem_data;
  logic [3:0] cs;
  dcp_dump #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(WPL), .MAX_LINES(MAXL), .RD_LAT(RD_LAT), .CMD_CODE(8'h44)) dut (
    .clk(clk), .rstn(rstn), .sel_mode(sel_mode), .req_rx(req_rx), .type_rx(type_rx), .ack_rx(ack_rx),
    .flag_rx(flag_rx), .din_rx(din_rx), .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx), .ack_tx(ack_tx),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .finish(finish), .cs(cs)
  );
  always #5 clk = ~clk;
  // memory returns ~addr only in the single valid cycle, garbage otherwise
  logic [RD_LAT-1:0] pv = '0;
  logic [31:0] pa [RD_LAT];
  always @(posedge clk) begin
    pv <= {pv[RD_LAT-2:0], mem_rd};
    pa[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
  end
  assign mem_data = pv[RD_LAT-1] ? ~pa[RD_LAT-1] : 32'hDEADBEEF;
  typedef struct { logic fa; logic [31:0] addr; logic fc; logic [31:0] cnt; int lines; logic [31:0] last; } vec_t;
  typedef struct packed { logic t; logic [31:0] d; } tx_t;
  vec_t vecs[8];
  tx_t sbq[$];
  int checks = 0, errors = 0, tx_cnt = 0;
  logic [31:0] m_last = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_exp(input logic [31:0] start, input int lines);
    logic [31:0] a = start;
    sbq.push_back({1'b0, 32'h44});
    sbq.push_back({1'b0, 32'h2D});
    for (int l = 0; l < lines; l++) begin
      sbq.push_back({1'b1, a});
      sbq.push_back({1'b0, 32'h3A});
      for (int w = 0; w < WPL; w++) begin
        sbq.push_back({1'b0, 32'h20});
        sbq.push_back({1'b1, ~a});
        a++;
      end
      sbq.push_back({1'b0, 32'h0D});
      sbq.push_back({1'b0, 32'h0A});
    end
  endtask
  task automatic rx_xfer(input logic flag, input logic [31:0] data, input string name);
    int n = 0;
    while (!req_rx && n < 100) begin @(negedge clk); n++; end
    if (!req_rx) begin
      checks++; errors++;
      $display("FAIL %s: req_rx got 0 expected 1 within 100 cycles", name);
    end else begin
      chk("type_rx", 32'(type_rx), 32'd1);
      ack_rx = 1'b1; flag_rx = flag; din_rx = data;
      @(negedge clk);
      ack_rx = 1'b0; flag_rx = 1'b0; din_rx = '0;
    end
  endtask
  task automatic start_cmd(input vec_t v);
    sel_mode = 8'h44;
    rx_xfer(v.fa, v.addr, "rx_addr");
    rx_xfer(v.fc, v.cnt, "rx_cnt");
  endtask
  task automatic run_cmd(input vec_t v);
    int n = 0;
    push_exp(v.fa ? m_last : v.addr, v.lines);
    tx_cnt = 0;
    sel_mode = 8'h44;
    @(negedge clk);
    ack_rx = 1'b1; din_rx = 32'h0BAD;
    @(negedge clk);
    ack_rx = 1'b0; din_rx = '0;
    rx_xfer(v.fa, v.addr, "rx_addr");
    rx_xfer(v.fc, v.cnt, "rx_cnt");
    while (!finish && n < 20000) begin @(negedge clk); n++; end
    chk("finish", 32'(finish), 32'd1);
    chk("tx_count", tx_cnt, 2 + v.lines * (4 + 2 * WPL));
    chk("sb_left", sbq.size(), 0);
    chk("last_addr", dut.last_addr_q, v.last);
    chk("req_tx_done", 32'(req_tx), 32'd0);
    sbq.delete();
    sel_mode = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("cs_idle", 32'(cs), 32'(IDLE));
    chk("finish_clr", 32'(finish), 32'd0);
    m_last = v.last;
  endtask
  task automatic chk_reset_outputs();
    chk("rst_req_rx", 32'(req_rx), 0);
    chk("rst_type_rx", 32'(type_rx), 1);
    chk("rst_req_tx", 32'(req_tx), 0);
    chk("rst_type_tx", 32'(type_tx), 0);
    chk("rst_dout_tx", dout_tx, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_cs", 32'(cs), 32'(IDLE));
    chk("rst_last_addr", dut.last_addr_q, 0);
  endtask
  initial begin
    tx_t e;
    ack_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (req_tx && !ack_tx && $urandom_range(0, 2) != 0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %b/%h expected nothing", type_tx, dout_tx);
        end else begin
          e = sbq.pop_front();
          chk("tx_type", 32'(type_tx), 32'(e.t));
          chk("tx_data", dout_tx, e.d);
        end
        tx_cnt++;
        ack_tx = 1'b1;
      end else ack_tx = 1'b0;
    end
  end
  initial begin
    int n;
    vec_t v;
    sel_mode = 8'h00; ack_rx = 1'b0; flag_rx = 1'b0; din_rx = '0;
    vecs[0] = '{1'b0, 32'h100,      1'b0, 32'd1,   1,  32'h108};
    vecs[1] = '{1'b1, 32'hDEAD0000, 1'b0, 32'd2,   2,  32'h118};
    vecs[2] = '{1'b0, 32'h2000,     1'b0, 32'd0,   1,  32'h2008};
    vecs[3] = '{1'b0, 32'h40,       1'b0, 32'd100, 16, 32'hC0};
    vecs[4] = '{1'b0, 32'hFFFFFFFE, 1'b0, 32'd1,   1,  32'h6};
    vecs[5] = '{1'b1, 32'h1234,     1'b1, 32'd5,   1,  32'hE};
    vecs[6] = '{1'b0, 32'h500,      1'b0, 32'd16,  16, 32'h580};
    vecs[7] = '{1'b0, 32'h1000,     1'b0, 32'd17,  16, 32'h1080};
    #12;
    chk_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);
    // abort during the second line's data word
    v = '{1'b0, 32'h300, 1'b0, 32'd3, 3, 32'h0};
    push_exp(32'h300, 3);
    tx_cnt = 0;
    start_cmd(v);
    n = 0;
    while (!(cs == 4'(PR_DATA) && tx_cnt >= 25) && n < 5000) begin @(negedge clk); n++; end
    chk("abort_reach", 32'(cs == 4'(PR_DATA)), 1);
    sel_mode = 8'h00;
    @(posedge clk); #1;
    chk("abort_cs", 32'(cs), 32'(IDLE));
    chk("abort_req_tx", 32'(req_tx), 0);
    chk("abort_req_rx", 32'(req_rx), 0);
    chk("abort_mem_rd", 32'(mem_rd), 0);
    chk("abort_finish", 32'(finish), 0);
    chk("abort_last", dut.last_addr_q, 32'h308);
    sbq.delete();
    @(negedge clk);
    // asynchronous reset mid-line
    push_exp(32'h300, 3);
    tx_cnt = 0;
    start_cmd(v);
    n = 0;
    while (tx_cnt < 10 && n < 5000) begin @(negedge clk); n++; end
    chk("rst_reach", 32'(tx_cnt >= 10), 1);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs();
    sbq.delete();
    sel_mode = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    m_last = '0;
    run_cmd('{1'b1, 32'h7777, 1'b0, 32'd1, 1, 32'h8});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcp_dump.md
# dcp_dump

Parametrised memory-dump command processor for the serial debug unit. When the mode selector equals its command code, it receives a start address and a line count over the receive channel. It then prints one header plus one or more formatted lines of memory words over the transmit channel, and reports completion to the debug-unit top. It supersedes the fixed-format single-line dump by adding a configurable line length, a multi-line count with clamping, a pipelined memory read with configurable latency, and abort handling.

## Interface
Parameters:
- ADDR_W, 32, address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, memory word width; zero-extended to 32 on dout_tx.
- WORDS_PER_LINE, 8, words printed per line (1..64).
- MAX_LINES, 16, upper clamp on requested line count (1..2^16-1).
- RD_LAT, 1, cycles from mem_rd to valid mem_data (1..8).
- CMD_CODE, 8'h44, sel_mode value that enables the block.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- sel_mode  in  8  command selector; block is enabled while sel_mode == CMD_CODE.
- req_rx  out  1  receive request.
- type_rx  out  1  constant 1 (hex word).
- ack_rx  in  1  one-cycle receive acknowledge.
- flag_rx  in  1  valid with ack_rx; 1 = argument omitted.
- din_rx  in  32  received word, valid with ack_rx.
- req_tx  out  1  transmit request.
- type_tx  out  1  0 = ASCII char in dout_tx[7:0], 1 = hex word.
- dout_tx  out  32  transmit payload.
- ack_tx  in  1  one-cycle transmit acknowledge.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  DATA_W  read data.
- finish  out  1  command complete.
- cs  out  4  current state, for debug display.

## Operation
- States: IDLE, GET_ADDR, GET_CNT, HDR_D, HDR_DASH, PR_ADDR, PR_COLON, RD, WAIT_RD, PR_SP, PR_DATA, PR_CR, PR_LF, DONE.
- Normal flow:
  - IDLE → GET_ADDR when enabled.
  - GET_ADDR → GET_CNT → HDR_D ('D') → HDR_DASH ('-').
  - Per line: PR_ADDR (hex cur_addr) → PR_COLON (':').
  - Per word: RD → WAIT_RD → PR_SP (' ') → PR_DATA (hex word).
  - End of line: PR_CR (0x0D) → PR_LF (0x0A) → next line or DONE.
- Address argument:
  - flag_rx = 1 selects last_addr.
  - Otherwise the address is din_rx[ADDR_W-1:0].
- Count argument:
  - flag_rx = 1 or a value of 0 gives 1 line.
  - A value above MAX_LINES is clamped to MAX_LINES.
- cur_addr increments by 1 after each word is captured and wraps to 0.
- last_addr gets cur_addr on entry to PR_CR, so it holds the next unprinted address.
  - Only completed lines update it; an abort leaves it at the last completed line boundary.
- DONE holds finish = 1 until sel_mode leaves CMD_CODE, then returns to IDLE.
- Abort: sel_mode != CMD_CODE in any state other than IDLE forces IDLE on the next edge.
  - In that same edge, req_rx, req_tx, mem_rd and finish clear.
  - Pending read data is discarded.
- Reset values:
  - All outputs 0 except type_rx = 1.
  - cs = IDLE, last_addr = 0, cur_addr = 0.

## Timing
- All outputs are registered.
- A request state raises its req one cycle after state entry.
- req, type and dout stay stable until ack is sampled high.
- On the ack edge, req falls and the state advances.
- Back-to-back transfers therefore have at least one req-low cycle between them.
- An ack while req is low is ignored.
- RD: mem_addr = cur_addr and mem_rd = 1 for exactly one cycle.
- WAIT_RD samples mem_data exactly RD_LAT cycles after the mem_rd cycle, then enters PR_SP.
- Transmit count per command: 2 + lines × (4 + 2 × WORDS_PER_LINE).
- Reset asserted mid-command returns every output to its reset value immediately (asynchronous).
- Simultaneous abort and ack: abort wins and no state advance occurs.

## Structure
- Package dcp_pkg holds:
  - ASCII constants: CH_D 8'h44, CH_DASH 8'h2D, CH_COLON 8'h3A, CH_SP 8'h20, CH_CR 8'h0D, CH_LF 8'h0A.
  - TX_CHAR / TX_HEX type codes.
  - The state encoding.
  - Command codes shared with the other command processors.
- One sub-module, dcp_req_hs: a generic req/ack holder with payload register.
  - Instantiated once for receive and once for transmit.
  - Its clear input is driven by abort.
- The read-latency shift register stays inline.

## Test plan
- Address 0x100, count 1, WORDS_PER_LINE = 8, memory model returns ~addr → tx sequence 'D','-',hex 0x100,':', then (' ', hex ~0x100) … (' ', hex ~0x107), CR, LF; finish = 1; last_addr = 0x108.
- Continuation: immediately after the previous command, flag_rx = 1 on the address and count 2 → lines start at 0x108 and 0x110; 42 tx transfers; last_addr = 0x118.
- Count clamp: count 0 → 1 line; count 100 with MAX_LINES = 16 → 16 lines, 322 tx transfers.
- Wrap: address 0xFFFFFFFE, count 1 → word addresses FFFFFFFE, FFFFFFFF, 0, 1, 2, 3, 4, 5; last_addr = 6.
- RD_LAT = 3; memory model drives 0xDEADBEEF except in the valid cycle → only correct words are printed.
- Abort: sel_mode changed during the 2nd line's PR_DATA → IDLE on the next cycle, all reqs low, finish = 0, last_addr = the 2nd line's start address. Repeat the command after rstn is pulsed mid-line → all outputs at reset values and last_addr = 0.
